// File: rtl/frame_reader_pkg.sv
// Shared types and constants for the SDRAM frame reader.
package frame_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fr_state_t;

  localparam int unsigned FR_BYTES_PER_WORD = 2;
  localparam logic [1:0]  FR_BYTEENABLE     = 2'b11;

endpackage

// File: rtl/frame_reader_fifo.sv
// 17-bit show-ahead FIFO ({sof, pixel}); the head entry is visible on rd_data
// whenever the FIFO is not empty.
module frame_reader_fifo
  import frame_reader_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [16:0]                wr_data,
  input  logic                       pop,
  output logic [16:0]                rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [16:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A full FIFO still takes a push when it is popped in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/sdram_frame_reader.sv
// Avalon-MM read master fetching one frame of RGB565 pixels into a local FIFO
// and streaming them out; reads are only issued when the FIFO has a slot reserved.
module sdram_frame_reader
  import frame_reader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          H_PIXELS    = 640,
  parameter int          V_LINES     = 480,
  parameter int          FIFO_DEPTH  = 64,
  parameter int          MAX_PENDING = 8
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        frame_start,
  output logic [31:0] m_address,
  output logic        m_read,
  input  logic        m_waitrequest,
  input  logic [15:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic        m_burstcount,
  output logic [1:0]  m_byteenable,
  output logic        m_write,
  output logic [15:0] m_writedata,
  output logic        m_debugaccess,
  output logic [15:0] pix_data,
  output logic        pix_sof,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        busy,
  output logic        rdv_error
);

  localparam int N   = H_PIXELS * V_LINES;
  localparam int WCW = $clog2(N+1);
  localparam int PW  = $clog2(MAX_PENDING+1);
  localparam int FCW = $clog2(FIFO_DEPTH+1);
  localparam int CW  = $clog2(FIFO_DEPTH+MAX_PENDING+2);

  fr_state_t      state_q, state_d;
  logic [WCW-1:0] word_q, word_d;
  logic [31:0]    addr_q, addr_d;
  logic           read_q, read_d;
  logic [PW-1:0]  pending_q, pending_d;
  logic           first_q, first_d;
  logic           err_q, err_d;

  logic           accept, stray, push, pop;
  logic [CW-1:0]  credit_sum;
  logic [16:0]    fifo_rd;
  logic [FCW-1:0] fifo_count;
  logic           fifo_full, fifo_empty;

  assign accept = read_q & ~m_waitrequest;
  assign stray  = m_readdatavalid & (pending_q == '0);
  assign push   = m_readdatavalid & ~stray;
  assign pop    = pix_valid & pix_ready;

  // Words already in the FIFO plus words owed to it; ignoring this cycle's pop
  // keeps the estimate conservative.
  assign credit_sum = CW'(fifo_count) + CW'(pending_q) + CW'(accept);

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    addr_d    = addr_q;
    pending_d = pending_q;
    first_d   = first_q;
    err_d     = err_q | stray;
    read_d    = 1'b0;

    case ({accept, push})
      2'b10:   pending_d = pending_q + PW'(1);
      2'b01:   pending_d = pending_q - PW'(1);
      default: pending_d = pending_q;
    endcase
    if (push) first_d = 1'b0;

    case (state_q)
      IDLE: if (frame_start) begin
        state_d = FETCH;
        word_d  = '0;
        addr_d  = BASE_ADDR;
        first_d = 1'b1;
      end
      FETCH: if (accept) begin
        word_d = word_q + WCW'(1);
        addr_d = addr_q + 32'(FR_BYTES_PER_WORD);
        if (word_q == WCW'(N-1)) state_d = DRAIN;
      end
      DRAIN: if (pending_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A stalled request is held as-is; otherwise decide on the next request.
    if (read_q & m_waitrequest)
      read_d = 1'b1;
    else
      read_d = (state_d == FETCH) && (credit_sum < CW'(FIFO_DEPTH))
            && (pending_d < PW'(MAX_PENDING)) && ~fifo_full;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q   <= IDLE;
      word_q    <= '0;
      addr_q    <= BASE_ADDR;
      read_q    <= 1'b0;
      pending_q <= '0;
      first_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      addr_q    <= addr_d;
      read_q    <= read_d;
      pending_q <= pending_d;
      first_q   <= first_d;
      err_q     <= err_d;
    end
  end

  frame_reader_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .push    (push),
    .wr_data ({first_q, m_readdata}),
    .pop     (pop),
    .rd_data (fifo_rd),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign pix_valid = ~fifo_empty;
  assign pix_data  = fifo_empty ? 16'h0000 : fifo_rd[15:0];
  assign pix_sof   = ~fifo_empty & fifo_rd[16];

  assign m_address     = addr_q;
  assign m_read        = read_q;
  assign m_burstcount  = 1'b1;
  assign m_byteenable  = FR_BYTEENABLE;
  assign m_write       = 1'b0;
  assign m_writedata   = 16'h0000;
  assign m_debugaccess = 1'b0;
  assign busy          = (state_q != IDLE);
  assign rdv_error     = err_q;

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Directed bench: Avalon slave model with fixed read latency feeding a pixel
// scoreboard; directed steps cover stalls, backpressure, latency and reset.
module tb_sdram_frame_reader;
  localparam logic [31:0] BASE = 32'h100;
  localparam int N  = 8;
  localparam int MP = 4;

  logic        clk = 1'b0, rst = 1'b0, frame_start = 1'b0;
  logic        m_waitrequest = 1'b0, m_readdatavalid = 1'b0, pix_ready = 1'b0;
  logic [15:0] m_readdata = 16'h0;
  logic [31:0] m_address;
  logic        m_read, m_burstcount, m_write, m_debugaccess;
  logic [1:0]  m_byteenable;
  logic [15:0] m_writedata, pix_data;
  logic        pix_sof, pix_valid, busy, rdv_error;

  sdram_frame_reader #(.BASE_ADDR(BASE), .H_PIXELS(4), .V_LINES(2),
                       .FIFO_DEPTH(8), .MAX_PENDING(MP)) dut (
    .clk_clk(clk), .reset_reset(rst), .frame_start(frame_start),
    .m_address(m_address), .m_read(m_read), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .m_burstcount(m_burstcount), .m_byteenable(m_byteenable), .m_write(m_write),
    .m_writedata(m_writedata), .m_debugaccess(m_debugaccess),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .busy(busy), .rdv_error(rdv_error));

  always #5 clk = ~clk;

  typedef struct packed { logic sof; logic [15:0] data; } pix_t;

  int n_checks = 0, n_fail = 0;
  int lat = 1, cyc = 0;
  int acc_cnt = 0, ret_cnt = 0, outstanding = 0, max_out = 0;
  logic [31:0] exp_addr = BASE;
  logic        next_sof = 1'b0;
  pix_t        exp_q[$];
  int          due_q[$];
  logic [15:0] dat_q[$];

  function automatic logic [15:0] mem_data(logic [31:0] a);
    return a[15:0] ^ 16'hC3A5;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave + scoreboard, sampling mid-cycle.
  always @(negedge clk) begin
    pix_t e;
    cyc++;
    if (rst) exp_q.delete();
    if (frame_start && !busy) begin
      exp_addr = BASE;
      next_sof = 1'b1;
    end
    m_readdatavalid = 1'b0;
    if (due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      m_readdata      = dat_q.pop_front();
      m_readdatavalid = 1'b1;
      ret_cnt++;
      outstanding--;
    end
    if (m_read && !m_waitrequest) begin
      check("accept_addr", m_address, exp_addr);
      exp_addr = exp_addr + 32'd2;
      acc_cnt++;
      outstanding++;
      if (outstanding > max_out) max_out = outstanding;
      check("outstanding_le_max", 32'(outstanding <= MP), 32'd1);
      due_q.push_back(cyc + lat);
      dat_q.push_back(mem_data(m_address));
      exp_q.push_back('{sof: next_sof, data: mem_data(m_address)});
      next_sof = 1'b0;
    end
    if (pix_valid && pix_ready) begin
      if (exp_q.size() == 0) check("pix_unexpected", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("pix_data", 32'(pix_data), 32'(e.data));
        check("pix_sof", 32'(pix_sof), 32'(e.sof));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int i;
    for (i = 0; i < budget && busy; i++) tick();
    if (busy) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_m_read"}, 32'(m_read), 32'd0);
    check({tag, "_m_address"}, m_address, BASE);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_pix_sof"}, 32'(pix_sof), 32'd0);
    check({tag, "_pix_data"}, 32'(pix_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int a0, r0;
    logic found;
    rst = 1'b1;
    tick(); tick();
    check_reset_vals("reset");
    check("reset_rdv_error", 32'(rdv_error), 32'd0);
    check("const_burstcount", 32'(m_burstcount), 32'd1);
    check("const_byteenable", 32'(m_byteenable), 32'd3);
    check("const_write", 32'(m_write), 32'd0);
    check("const_writedata", 32'(m_writedata), 32'd0);
    check("const_debugaccess", 32'(m_debugaccess), 32'd0);
    rst = 1'b0;
    tick();

    // Basic frame, single-cycle return latency.
    lat = 1; pix_ready = 1'b1;
    a0 = acc_cnt; r0 = ret_cnt;
    pulse_start();
    check("basic_read_t1", 32'(m_read), 32'd1);
    check("basic_addr_t1", m_address, BASE);
    wait_idle(100);
    check("basic_accepts", 32'(acc_cnt - a0), 32'd8);
    check("basic_returns_at_idle", 32'(ret_cnt - r0), 32'd8);
    tick(); tick();
    check("basic_sb_empty", 32'(exp_q.size()), 32'd0);
    check("basic_pix_valid_low", 32'(pix_valid), 32'd0);

    // Waitrequest stall on word 3.
    a0 = acc_cnt;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_read && m_address == BASE + 32'h6) found = 1'b1;
      else tick();
    end
    check("wait_found_word3", 32'(found), 32'd1);
    m_waitrequest = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("wait_hold_read", 32'(m_read), 32'd1);
      check("wait_hold_addr", m_address, BASE + 32'h6);
    end
    m_waitrequest = 1'b0;
    wait_idle(100);
    check("wait_accepts", 32'(acc_cnt - a0), 32'd8);

    // Backpressure: stream stalled, FIFO fills, credit blocks a second frame.
    tick(); tick();
    lat = 3; pix_ready = 1'b0;
    a0 = acc_cnt;
    pulse_start();
    for (int i = 0; i < 30; i++) tick();
    check("bp_accepts", 32'(acc_cnt - a0), 32'd8);
    check("bp_busy_low", 32'(busy), 32'd0);
    check("bp_pix_valid", 32'(pix_valid), 32'd1);
    check("bp_hold_data", 32'(pix_data), 32'(mem_data(BASE)));
    check("bp_hold_sof", 32'(pix_sof), 32'd1);
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      check("bp_full_no_read", 32'(m_read), 32'd0);
      check("bp_full_busy", 32'(busy), 32'd1);
      tick();
    end
    pix_ready = 1'b1;
    wait_idle(200);
    check("bp_accepts_two_frames", 32'(acc_cnt - a0), 32'd16);
    tick(); tick(); tick(); tick();
    check("bp_sb_empty", 32'(exp_q.size()), 32'd0);
    check("bp_pix_valid_low", 32'(pix_valid), 32'd0);

    // Long pipelined latency.
    lat = 6;
    a0 = acc_cnt; r0 = ret_cnt;
    pulse_start();
    wait_idle(200);
    check("lat_accepts", 32'(acc_cnt - a0), 32'd8);
    check("lat_returns_at_idle", 32'(ret_cnt - r0), 32'd8);
    check("lat_max_outstanding", 32'(max_out), 32'(MP));

    // Restart attempt mid-frame is ignored.
    lat = 1;
    a0 = acc_cnt;
    pulse_start();
    tick();
    pulse_start();
    wait_idle(100);
    check("restart_ignored_accepts", 32'(acc_cnt - a0), 32'd8);
    a0 = acc_cnt;
    pulse_start();
    check("restart_new_read", 32'(m_read), 32'd1);
    check("restart_new_addr", m_address, BASE);
    wait_idle(100);
    check("restart_new_accepts", 32'(acc_cnt - a0), 32'd8);
    tick(); tick();

    // Reset with three reads in flight.
    lat = 6;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (outstanding == 3) found = 1'b1;
      else tick();
    end
    check("rst_three_pending", 32'(found), 32'd1);
    rst = 1'b1;
    tick();
    check_reset_vals("midrst");
    check("midrst_rdv_error", 32'(rdv_error), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("stray_all_returned", 32'(outstanding), 32'd0);
    check("stray_rdv_error", 32'(rdv_error), 32'd1);
    check("stray_no_push", 32'(pix_valid), 32'd0);
    check("stray_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
